// File: rtl/gshare_predictor_pkg.sv
// Shared definitions for the gshare branch predictor: opcodes, counter states,
// instruction classification and RISC-V branch/jump immediate extraction.
// Pure declarations; no timing or flow-control behaviour of its own.
package gshare_predictor_pkg;

    // RV32 opcodes that the predictor distinguishes
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Two-bit saturating counter encodings
    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } cnt_e;

    // Classes of fetched instruction as seen by the predictor
    typedef enum logic [1:0] {
        INST_OTHER  = 2'd0,
        INST_BRANCH = 2'd1,
        INST_JAL    = 2'd2
    } inst_kind_e;

    // JALR and every other opcode fall into INST_OTHER
    function automatic inst_kind_e decode_kind(input logic [6:0] opc);
        inst_kind_e kind;
        case (opc)
            OPC_BRANCH: kind = INST_BRANCH;
            OPC_JAL:    kind = INST_JAL;
            default:    kind = INST_OTHER;
        endcase
        return kind;
    endfunction

    // Sign-extended B-type immediate
    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    // Sign-extended J-type immediate
    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// Fetch/predict/commit bundle between the fetcher/ROB and the gshare predictor.
// Prediction outputs are combinational (zero cycles); commit is a one-cycle pulse.
// No backpressure: fetch and commit are accepted whenever the global rdy is high.
// Ports: if_* fetch request, pred_* prediction, commit_* ROB training.
// With GHR_W = 0 the history is meaningless, so pred_ghr shrinks to one
// bit that is always zero.
interface gshare_predictor_if #(
    parameter int IDX_W = 7,
    parameter int GHR_W = 6
);
    localparam int GHR_SW = (GHR_W > 0) ? GHR_W : 1;

    // fetch side
    logic              if_valid;
    logic [31:0]       if_pc;
    logic [31:0]       if_inst;

    // prediction
    logic              pred_taken;
    logic [31:0]       pred_pc;
    logic [IDX_W-1:0]  pred_idx;
    logic [GHR_SW-1:0] pred_ghr;

    // ROB commit / training
    logic              commit_valid;
    logic [IDX_W-1:0]  commit_idx;
    logic              commit_taken;
    logic              commit_mispredict;

    // fetcher / ROB side
    modport master (
        output if_valid, if_pc, if_inst,
        output commit_valid, commit_idx, commit_taken, commit_mispredict,
        input  pred_taken, pred_pc, pred_idx, pred_ghr
    );

    // predictor side
    modport slave (
        input  if_valid, if_pc, if_inst,
        input  commit_valid, commit_idx, commit_taken, commit_mispredict,
        output pred_taken, pred_pc, pred_idx, pred_ghr
    );

endinterface

// File: rtl/gshare_predictor_sat_counter2.sv
// Next-state of one 2-bit saturating direction counter.
// Purely combinational, zero latency.
// No flow control; the caller decides when the result is written back.
// Ports: cur (present state), taken (resolved direction), nxt (next state).
module sat_counter2
    import gshare_predictor_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       taken,
    output logic [1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (taken) begin
            if (cur != CNT_ST) begin
                nxt = cur + 2'd1;
            end
        end else begin
            if (cur != CNT_SNT) begin
                nxt = cur - 2'd1;
            end
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// gshare direction/next-PC predictor: PHT indexed by PC XOR speculative history.
// Prediction is combinational (zero cycles); training lands on the next clk edge.
// No backpressure; rdy low freezes all state while outputs keep tracking inputs.
// Ports: clk, rst (async active-low), rdy, bp (slave side of gshare_predictor_if).
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int         IDX_W    = 7,
    parameter int         GHR_W    = 6,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    gshare_predictor_if.slave   bp
);

    localparam int N_ENT  = 1 << IDX_W;
    localparam int GHR_SW = (GHR_W > 0) ? GHR_W : 1;

    // Shift one outcome into the youngest position of a history register
    function automatic logic [GHR_SW-1:0] shift_in(input logic [GHR_SW-1:0] ghr,
                                                   input logic              bit_in);
        logic [GHR_SW:0] tmp;
        tmp = {ghr, bit_in};
        return tmp[GHR_SW-1:0];
    endfunction

    logic [1:0]        pht_q [N_ENT];
    logic [GHR_SW-1:0] spec_ghr_q, spec_ghr_d;
    logic [GHR_SW-1:0] cmt_ghr_q,  cmt_ghr_d;

    inst_kind_e        kind;
    logic [IDX_W-1:0]  fetch_idx;
    logic              pred_taken;
    logic [31:0]       pred_pc;
    logic [1:0]        cnt_nxt;
    logic              commit_en;

    // ---------------------------------------------------------------
    // Predict path
    // ---------------------------------------------------------------
    assign kind = decode_kind(bp.if_inst[6:0]);

    // History is zero-extended into the low index bits; with GHR_W = 0 the
    // register is held at zero so this degenerates to a PC-indexed table.
    assign fetch_idx = bp.if_pc[IDX_W+1:2] ^ IDX_W'(spec_ghr_q);

    always_comb begin
        pred_taken = 1'b0;
        pred_pc    = bp.if_pc + 32'd4;
        case (kind)
            INST_BRANCH: begin
                pred_taken = pht_q[fetch_idx][1];
                if (pred_taken) begin
                    pred_pc = bp.if_pc + imm_b(bp.if_inst);
                end
            end
            INST_JAL: begin
                pred_taken = 1'b1;
                pred_pc    = bp.if_pc + imm_j(bp.if_inst);
            end
            default: begin
            end
        endcase
    end

    assign bp.pred_taken = pred_taken;
    assign bp.pred_pc    = pred_pc;
    assign bp.pred_idx   = fetch_idx;
    assign bp.pred_ghr   = spec_ghr_q;

    // ---------------------------------------------------------------
    // History update
    // ---------------------------------------------------------------
    assign commit_en = rdy & bp.commit_valid;

    always_comb begin
        spec_ghr_d = spec_ghr_q;
        cmt_ghr_d  = cmt_ghr_q;
        if (commit_en) begin
            cmt_ghr_d = shift_in(cmt_ghr_q, bp.commit_taken);
        end
        // A mispredict redirects the fetcher, so any same-cycle fetch is
        // discarded and its speculative shift must not survive.
        if (commit_en && bp.commit_mispredict) begin
            spec_ghr_d = shift_in(cmt_ghr_q, bp.commit_taken);
        end else if (rdy && bp.if_valid && (kind == INST_BRANCH)) begin
            spec_ghr_d = shift_in(spec_ghr_q, pred_taken);
        end
        if (GHR_W == 0) begin
            spec_ghr_d = '0;
            cmt_ghr_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spec_ghr_q <= '0;
            cmt_ghr_q  <= '0;
        end else begin
            spec_ghr_q <= spec_ghr_d;
            cmt_ghr_q  <= cmt_ghr_d;
        end
    end

    // ---------------------------------------------------------------
    // Pattern history table
    // ---------------------------------------------------------------
    sat_counter2 u_cnt (
        .cur   (pht_q[bp.commit_idx]),
        .taken (bp.commit_taken),
        .nxt   (cnt_nxt)
    );

    // The predict path reads pht_q directly, so a fetch hitting the entry
    // being trained this cycle sees the pre-update value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_ENT; i++) begin
                pht_q[i] <= CNT_INIT;
            end
        end else if (commit_en) begin
            pht_q[bp.commit_idx] <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor: one instance with 6-bit history and
// one degenerate bimodal instance (GHR_W = 0), driven by the same stimulus.
// Expected predictions are queued as stimulus is applied and compared on sampling.
module tb_gshare_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        if_valid = 1'b0;
    logic [31:0] if_pc = '0;
    logic [31:0] if_inst = '0;
    logic        commit_valid = 1'b0;
    logic [6:0]  commit_idx = '0;
    logic        commit_taken = 1'b0;
    logic        commit_mispredict = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        bit          sel0;
        logic        exp_taken;
        logic [31:0] exp_pc;
        logic [6:0]  exp_idx;
        logic [5:0]  exp_ghr;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    gshare_predictor_if #(.IDX_W(7), .GHR_W(6)) if6 ();
    gshare_predictor_if #(.IDX_W(7), .GHR_W(0)) if0 ();

    assign if6.if_valid          = if_valid;
    assign if6.if_pc             = if_pc;
    assign if6.if_inst           = if_inst;
    assign if6.commit_valid      = commit_valid;
    assign if6.commit_idx        = commit_idx;
    assign if6.commit_taken      = commit_taken;
    assign if6.commit_mispredict = commit_mispredict;

    assign if0.if_valid          = if_valid;
    assign if0.if_pc             = if_pc;
    assign if0.if_inst           = if_inst;
    assign if0.commit_valid      = commit_valid;
    assign if0.commit_idx        = commit_idx;
    assign if0.commit_taken      = commit_taken;
    assign if0.commit_mispredict = commit_mispredict;

    gshare_predictor #(.IDX_W(7), .GHR_W(6), .CNT_INIT(2'b01)) dut6 (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bp  (if6)
    );

    gshare_predictor #(.IDX_W(7), .GHR_W(0), .CNT_INIT(2'b01)) dut0 (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bp  (if0)
    );

    // Instruction encoders (inverse of the RISC-V immediate layouts)
    function automatic logic [31:0] enc_b(input logic [12:0] off);
        return {off[12], off[10:5], 5'd0, 5'd0, 3'b000, off[4:1], off[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] off);
        return {off[20], off[10:1], off[11], off[19:12], 5'd0, 7'b1101111};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fetch(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst;
    endtask

    task automatic set_commit(input logic v, input logic [6:0] idx, input logic t,
                              input logic mp);
        commit_valid      = v;
        commit_idx        = idx;
        commit_taken      = t;
        commit_mispredict = mp;
    endtask

    task automatic idle();
        if_valid = 1'b0;
        set_commit(1'b0, 7'd0, 1'b0, 1'b0);
    endtask

    task automatic commit_once(input logic [6:0] idx, input logic t, input logic mp);
        set_commit(1'b1, idx, t, mp);
        tick();
        idle();
    endtask

    task automatic expect_pred(input string tag, input bit sel0, input logic tk,
                               input logic [31:0] pc, input logic [6:0] ix,
                               input logic [5:0] g);
        exp_t e;
        e.tag = tag; e.sel0 = sel0; e.exp_taken = tk;
        e.exp_pc = pc; e.exp_idx = ix; e.exp_ghr = g;
        sb_q.push_back(e);
    endtask

    // Samples the prediction outputs and drains the scoreboard
    task automatic check_preds();
        exp_t        e;
        logic        t;
        logic [31:0] p;
        logic [6:0]  ix;
        logic [5:0]  g;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.sel0) begin
                t = if0.pred_taken; p = if0.pred_pc; ix = if0.pred_idx;
                g = {5'd0, if0.pred_ghr};
            end else begin
                t = if6.pred_taken; p = if6.pred_pc; ix = if6.pred_idx;
                g = if6.pred_ghr;
            end
            checks++;
            assert (t === e.exp_taken) else begin
                errors++;
                $error("FAIL %s pred_taken: got %0b want %0b", e.tag, t, e.exp_taken);
            end
            checks++;
            assert (p === e.exp_pc) else begin
                errors++;
                $error("FAIL %s pred_pc: got %08h want %08h", e.tag, p, e.exp_pc);
            end
            checks++;
            assert (ix === e.exp_idx) else begin
                errors++;
                $error("FAIL %s pred_idx: got %02h want %02h", e.tag, ix, e.exp_idx);
            end
            checks++;
            assert (g === e.exp_ghr) else begin
                errors++;
                $error("FAIL %s pred_ghr: got %02h want %02h", e.tag, g, e.exp_ghr);
            end
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    initial begin
        // real falling edge so the async reset branch fires
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // --- reset state
        set_fetch(1'b0, 32'h100, enc_b(13'd16));
        expect_pred("rst6", 1'b0, 1'b0, 32'h104, 7'h40, 6'h00);
        expect_pred("rst0", 1'b1, 1'b0, 32'h104, 7'h40, 6'h00);
        check_preds();

        // --- bimodal instance: saturation at both ends
        set_fetch(1'b0, 32'h100, enc_b(13'h1FF8));
        commit_once(7'h40, 1'b1, 1'b0);                      // 10
        expect_pred("bim_wt", 1'b1, 1'b1, 32'h0F8, 7'h40, 6'h00);
        check_preds();
        commit_once(7'h40, 1'b1, 1'b0);                      // 11
        commit_once(7'h40, 1'b1, 1'b0);                      // 11 (saturated)
        expect_pred("bim_st", 1'b1, 1'b1, 32'h0F8, 7'h40, 6'h00);
        check_preds();
        commit_once(7'h40, 1'b0, 1'b0);                      // 10
        expect_pred("bim_dec1", 1'b1, 1'b1, 32'h0F8, 7'h40, 6'h00);
        check_preds();
        commit_once(7'h40, 1'b0, 1'b0);                      // 01
        expect_pred("bim_wnt", 1'b1, 1'b0, 32'h104, 7'h40, 6'h00);
        check_preds();
        commit_once(7'h40, 1'b0, 1'b0);                      // 00
        commit_once(7'h40, 1'b0, 1'b0);                      // 00 (saturated)
        commit_once(7'h40, 1'b1, 1'b0);                      // 01
        expect_pred("bim_snt", 1'b1, 1'b0, 32'h104, 7'h40, 6'h00);
        check_preds();
        commit_once(7'h40, 1'b1, 1'b0);                      // 10
        expect_pred("bim_up", 1'b1, 1'b1, 32'h0F8, 7'h40, 6'h00);
        check_preds();

        // --- speculative history fill with taken-predicted branches
        pulse_reset();
        commit_once(7'h40, 1'b1, 1'b0);
        commit_once(7'h41, 1'b1, 1'b0);
        commit_once(7'h43, 1'b1, 1'b0);
        commit_once(7'h47, 1'b1, 1'b0);
        set_fetch(1'b1, 32'h100, enc_b(13'd16));
        expect_pred("ghr_f1", 1'b0, 1'b1, 32'h110, 7'h40, 6'h00);
        check_preds();
        tick();
        expect_pred("ghr_f2", 1'b0, 1'b1, 32'h110, 7'h41, 6'h01);
        check_preds();
        tick();
        expect_pred("ghr_f3", 1'b0, 1'b1, 32'h110, 7'h43, 6'h03);
        check_preds();
        tick();
        expect_pred("ghr_f4", 1'b0, 1'b1, 32'h110, 7'h47, 6'h07);
        check_preds();
        tick();
        idle();
        expect_pred("ghr_full", 1'b0, 1'b0, 32'h104, 7'h4F, 6'h0F);
        check_preds();

        // --- mispredict repair from committed history 000101
        pulse_reset();
        commit_once(7'h10, 1'b1, 1'b0);
        commit_once(7'h10, 1'b0, 1'b0);
        commit_once(7'h10, 1'b1, 1'b0);
        set_fetch(1'b1, 32'h100, enc_b(13'd16));
        set_commit(1'b1, 7'h20, 1'b0, 1'b1);
        expect_pred("mp_pre", 1'b0, 1'b0, 32'h104, 7'h40, 6'h00);
        check_preds();
        tick();
        idle();
        expect_pred("mp_fix0", 1'b0, 1'b0, 32'h104, 7'h4A, 6'h0A);
        check_preds();
        commit_once(7'h20, 1'b1, 1'b1);
        expect_pred("mp_fix1", 1'b0, 1'b0, 32'h104, 7'h55, 6'h15);
        check_preds();

        // --- JAL with address wrap, no history update; JALR is "other"
        set_fetch(1'b1, 32'hFFFF_FFF0, enc_j(21'h20));
        expect_pred("jal", 1'b0, 1'b1, 32'h0000_0010, 7'h69, 6'h15);
        check_preds();
        tick();
        set_fetch(1'b0, 32'h200, 32'h0000_8067);
        expect_pred("jalr", 1'b0, 1'b0, 32'h204, 7'h15, 6'h15);
        check_preds();

        // --- rdy low freezes counters and both histories
        rdy = 1'b0;
        set_fetch(1'b1, 32'h100, enc_b(13'd16));
        set_commit(1'b1, 7'h55, 1'b1, 1'b1);
        tick();
        rdy = 1'b1;
        idle();
        expect_pred("rdy_frz", 1'b0, 1'b0, 32'h104, 7'h55, 6'h15);
        check_preds();
        commit_once(7'h30, 1'b0, 1'b1);
        expect_pred("rdy_cmt", 1'b0, 1'b0, 32'h104, 7'h6A, 6'h2A);
        check_preds();

        // --- asynchronous reset mid-stream
        commit_once(7'h40, 1'b1, 1'b0);
        commit_once(7'h40, 1'b1, 1'b0);
        set_fetch(1'b0, 32'h100, enc_b(13'h1FF8));
        expect_pred("pre_rst0", 1'b1, 1'b1, 32'h0F8, 7'h40, 6'h00);
        check_preds();
        rst = 1'b0;
        expect_pred("arst0", 1'b1, 1'b0, 32'h104, 7'h40, 6'h00);
        expect_pred("arst6", 1'b0, 1'b0, 32'h104, 7'h40, 6'h00);
        check_preds();
        rst = 1'b1;
        commit_once(7'h01, 1'b1, 1'b1);
        set_fetch(1'b0, 32'h100, enc_b(13'd16));
        expect_pred("arst_cmt", 1'b0, 1'b0, 32'h104, 7'h41, 6'h01);
        check_preds();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
